// File: rtl/ysyx_22040759_idex_stage_pkg.sv
// Shared types and constants for the ID->EX stage: operand bundle layout,
// ALU select codes used as bubble/reset values, and occupancy encodings.
package ysyx_22040759_idex_stage_pkg;

    localparam int XLEN  = 64;
    localparam int SEL_W = 3;
    localparam int RD_W  = 5;

    localparam logic [SEL_W-1:0] ALU_ADD = 3'd0;
    localparam logic [SEL_W-1:0] ALU_OR  = 3'd2;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]  alu_a;
        logic [XLEN-1:0]  alu_b;
        logic [SEL_W-1:0] alu_sel;
        logic [RD_W-1:0]  rd;
        logic             rf_wen;
        logic [XLEN-1:0]  pc;
    } idex_payload_t;

    // 0 + 0 with no writeback: a harmless bubble if ever consumed
    localparam idex_payload_t PAYLOAD_BUBBLE = '{
        alu_a:   64'd0,
        alu_b:   64'd0,
        alu_sel: ALU_ADD,
        rd:      5'd0,
        rf_wen:  1'b0,
        pc:      64'd0
    };

endpackage

// File: rtl/ysyx_22040759_pipe_slot.sv
// One pipeline holding slot: payload register plus valid bit.
// Clear drops only the valid bit; the payload is left in place.
module ysyx_22040759_pipe_slot
    import ysyx_22040759_idex_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  idex_payload_t d,
    output idex_payload_t q,
    output logic          valid
);

    idex_payload_t data_r;
    logic          valid_r;

    // Slot storage: clear has priority over load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= PAYLOAD_BUBBLE;
            valid_r <= 1'b0;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= d;
            valid_r <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign q     = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/ysyx_22040759_idex_stage.sv
// ID->EX pipeline stage: two-slot skid buffer (main + skid) so that id_ready
// comes straight from a flop while still sustaining one beat per cycle.
module ysyx_22040759_idex_stage
    import ysyx_22040759_idex_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_alu_a,
    input  logic [XLEN-1:0]  id_alu_b,
    input  logic [SEL_W-1:0] id_alu_sel,
    input  logic [RD_W-1:0]  id_rd,
    input  logic             id_rf_wen,
    input  logic [XLEN-1:0]  id_pc,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_alu_a,
    output logic [XLEN-1:0]  ex_alu_b,
    output logic [SEL_W-1:0] ex_alu_sel,
    output logic [RD_W-1:0]  ex_rd,
    output logic             ex_rf_wen,
    output logic [XLEN-1:0]  ex_pc,
    output logic [1:0]       occupancy
);

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    idex_payload_t id_payload_s;
    idex_payload_t main_d_s;
    idex_payload_t main_q_s;
    idex_payload_t skid_q_s;
    logic          main_valid_s;
    logic          skid_valid_s;
    logic          main_load_s;
    logic          main_clear_s;
    logic          skid_load_s;
    logic          skid_clear_s;
    logic          acc_s;
    logic          pop_s;

    assign id_payload_s = '{
        alu_a:   id_alu_a,
        alu_b:   id_alu_b,
        alu_sel: id_alu_sel,
        rd:      id_rd,
        rf_wen:  id_rf_wen,
        pc:      id_pc
    };

    assign id_ready = ~skid_valid_s;
    assign ex_valid = main_valid_s;
    assign acc_s    = id_valid & id_ready;
    assign pop_s    = ex_valid & ex_ready;

    // Next-state and slot enables; flush drops every held beat and any offer
    always_comb begin
        state_nxt_s  = state_r;
        main_d_s     = id_payload_s;
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        if (flush) begin
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
            state_nxt_s  = OCC_EMPTY;
        end else begin
            case (state_r)
                OCC_EMPTY: begin
                    if (acc_s) begin
                        main_load_s = 1'b1;
                        state_nxt_s = OCC_ONE;
                    end else begin
                        state_nxt_s = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (acc_s && pop_s) begin
                        main_load_s = 1'b1;
                    end else if (acc_s) begin
                        skid_load_s = 1'b1;
                        state_nxt_s = OCC_FULL;
                    end else if (pop_s) begin
                        main_clear_s = 1'b1;
                        state_nxt_s  = OCC_EMPTY;
                    end else begin
                        state_nxt_s = OCC_ONE;
                    end
                end
                OCC_FULL: begin
                    if (pop_s) begin
                        main_d_s     = skid_q_s;
                        main_load_s  = 1'b1;
                        skid_clear_s = 1'b1;
                        state_nxt_s  = OCC_ONE;
                    end else begin
                        state_nxt_s = OCC_FULL;
                    end
                end
                default: begin
                    main_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                    state_nxt_s  = OCC_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register; mirrors the two slot valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= OCC_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    ysyx_22040759_pipe_slot u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load_s),
        .clear (main_clear_s),
        .d     (main_d_s),
        .q     (main_q_s),
        .valid (main_valid_s)
    );

    ysyx_22040759_pipe_slot u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load_s),
        .clear (skid_clear_s),
        .d     (id_payload_s),
        .q     (skid_q_s),
        .valid (skid_valid_s)
    );

    assign ex_alu_a   = main_q_s.alu_a;
    assign ex_alu_b   = main_q_s.alu_b;
    assign ex_alu_sel = main_q_s.alu_sel;
    assign ex_rd      = main_q_s.rd;
    assign ex_rf_wen  = main_q_s.rf_wen;
    assign ex_pc      = main_q_s.pc;
    assign occupancy  = state_r;

endmodule

// File: tb/tb_ysyx_22040759_idex_stage.sv
// Bench for the ID->EX stage: a FIFO-queue model of the stage checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ysyx_22040759_idex_stage;
    import ysyx_22040759_idex_stage_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_alu_a;
    logic [XLEN-1:0]  id_alu_b;
    logic [SEL_W-1:0] id_alu_sel;
    logic [RD_W-1:0]  id_rd;
    logic             id_rf_wen;
    logic [XLEN-1:0]  id_pc;
    logic             ex_valid;
    logic             ex_ready;
    logic [XLEN-1:0]  ex_alu_a;
    logic [XLEN-1:0]  ex_alu_b;
    logic [SEL_W-1:0] ex_alu_sel;
    logic [RD_W-1:0]  ex_rd;
    logic             ex_rf_wen;
    logic [XLEN-1:0]  ex_pc;
    logic [1:0]       occupancy;

    int total = 0;
    int bad   = 0;

    idex_payload_t    model_q[$];
    logic [XLEN-1:0]  popped[$];
    logic             seen_200;
    int               occ_max;

    ysyx_22040759_idex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_alu_a   (id_alu_a),
        .id_alu_b   (id_alu_b),
        .id_alu_sel (id_alu_sel),
        .id_rd      (id_rd),
        .id_rf_wen  (id_rf_wen),
        .id_pc      (id_pc),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_alu_a   (ex_alu_a),
        .ex_alu_b   (ex_alu_b),
        .ex_alu_sel (ex_alu_sel),
        .ex_rd      (ex_rd),
        .ex_rf_wen  (ex_rf_wen),
        .ex_pc      (ex_pc),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: the stage is a FIFO of depth 2; check outputs then apply this cycle's transfer
    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
            chk("rst_id_ready", {63'd0, id_ready}, 64'd1);
            chk("rst_occ", {62'd0, occupancy}, 64'd0);
        end else begin
            int  n;
            logic m_acc;
            logic m_pop;
            idex_payload_t beat;
            n = model_q.size();
            chk("ex_valid", {63'd0, ex_valid}, (n > 0) ? 64'd1 : 64'd0);
            chk("id_ready", {63'd0, id_ready}, (n < 2) ? 64'd1 : 64'd0);
            chk("occupancy", {62'd0, occupancy}, 64'(n));
            if (n > 0) begin
                chk("ex_alu_a", ex_alu_a, model_q[0].alu_a);
                chk("ex_alu_b", ex_alu_b, model_q[0].alu_b);
                chk("ex_alu_sel", {61'd0, ex_alu_sel}, {61'd0, model_q[0].alu_sel});
                chk("ex_rd", {59'd0, ex_rd}, {59'd0, model_q[0].rd});
                chk("ex_rf_wen", {63'd0, ex_rf_wen}, {63'd0, model_q[0].rf_wen});
                chk("ex_pc", ex_pc, model_q[0].pc);
            end
            if (ex_valid && ex_ready) begin
                popped.push_back(ex_pc);
                if (ex_pc == 64'h200) seen_200 = 1'b1;
            end
            if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
            m_acc = id_valid && (n < 2);
            m_pop = (n > 0) && ex_ready;
            beat  = '{alu_a: id_alu_a, alu_b: id_alu_b, alu_sel: id_alu_sel,
                      rd: id_rd, rf_wen: id_rf_wen, pc: id_pc};
            if (flush) begin
                model_q.delete();
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (m_acc) model_q.push_back(beat);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        id_valid   = 1'b0;
        ex_ready   = 1'b0;
        id_alu_a   = 64'd0;
        id_alu_b   = 64'd0;
        id_alu_sel = ALU_ADD;
        id_rd      = 5'd0;
        id_rf_wen  = 1'b0;
        id_pc      = 64'd0;
        seen_200   = 1'b0;
        occ_max    = 0;
        step();
        step();
        rst_n = 1'b1;

        // Streaming: one beat per cycle with ex_ready held high
        id_valid   = 1'b1;
        ex_ready   = 1'b1;
        id_alu_a   = 64'h11;
        id_alu_b   = 64'h22;
        id_alu_sel = ALU_ADD;
        id_rd      = 5'd3;
        id_rf_wen  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            id_pc = 64'h8000_0000 + 64'(4 * i);
            step();
        end
        chk("stream_last_pc", ex_pc, 64'h8000_0024);
        chk("stream_occ", {62'd0, occupancy}, 64'd1);
        id_valid = 1'b0;
        step();
        step();

        // Backpressure: A, B fill the stage, C stalls until space frees
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_pc    = 64'h100;
        step();
        id_pc = 64'h104;
        step();
        id_pc = 64'h108;
        step();
        step();
        chk("bp_occ", {62'd0, occupancy}, 64'd2);
        chk("bp_id_ready", {63'd0, id_ready}, 64'd0);
        chk("bp_ex_pc", ex_pc, 64'h100);
        popped.delete();
        ex_ready = 1'b1;
        step();
        step();
        id_valid = 1'b0;
        step();
        step();
        chk("bp_pop_count", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            chk("bp_pop0", popped[0], 64'h100);
            chk("bp_pop1", popped[1], 64'h104);
            chk("bp_pop2", popped[2], 64'h108);
        end

        // Flush while full, with a beat offered in the flush cycle
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_pc    = 64'h180;
        step();
        id_pc = 64'h184;
        step();
        flush = 1'b1;
        id_pc = 64'h200;
        step();
        flush    = 1'b0;
        id_valid = 1'b0;
        chk("flush_ex_valid", {63'd0, ex_valid}, 64'd0);
        chk("flush_occ", {62'd0, occupancy}, 64'd0);
        chk("flush_id_ready", {63'd0, id_ready}, 64'd1);
        ex_ready = 1'b1;
        step();
        step();
        step();
        chk("flush_no_200", {63'd0, seen_200}, 64'd0);

        // Payload integrity under random handshakes
        id_alu_a   = 64'hFFFF_FFFF_FFFF_FFFF;
        id_alu_b   = 64'h1;
        id_alu_sel = ALU_OR;
        id_rd      = 5'd31;
        id_rf_wen  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            id_valid = 1'($urandom_range(0, 1));
            ex_ready = 1'($urandom_range(0, 1));
            id_pc    = 64'h1000 + 64'(4 * i);
            step();
        end
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_pc    = 64'h2000;
        step();
        chk("pi_ex_valid", {63'd0, ex_valid}, 64'd1);
        chk("pi_alu_a", ex_alu_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pi_alu_b", ex_alu_b, 64'h1);
        chk("pi_alu_sel", {61'd0, ex_alu_sel}, {61'd0, ALU_OR});
        chk("pi_rd", {59'd0, ex_rd}, 64'd31);
        chk("pi_rf_wen", {63'd0, ex_rf_wen}, 64'd1);
        id_valid = 1'b0;
        ex_ready = 1'b1;
        step();
        step();
        step();

        // Sustained accept+pop in ONE never fills the skid slot
        id_valid = 1'b1;
        id_pc    = 64'h3000;
        step();
        occ_max = 0;
        for (int i = 0; i < 100; i++) begin
            id_pc = 64'h3004 + 64'(4 * i);
            step();
        end
        chk("ss_occ_max", 64'(occ_max), 64'd1);
        chk("ss_last_pc", ex_pc, 64'h3190);

        // Asynchronous reset asserted mid-cycle with a beat held
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", {63'd0, ex_valid}, 64'd0);
        chk("arst_id_ready", {63'd0, id_ready}, 64'd1);
        chk("arst_occ", {62'd0, occupancy}, 64'd0);
        chk("arst_alu_sel", {61'd0, ex_alu_sel}, {61'd0, ALU_ADD});
        chk("arst_pc", ex_pc, 64'd0);
        id_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
